// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the hazard/forwarding unit: scoreboard entry layout and forward-select encoding.
package pipe_pkg;

    // Register fields are stored zero-extended to this width so one struct serves any REG_AW up to 8.
    localparam int SB_AW = 8;
    localparam int SEL_W = 4;

    typedef logic [SEL_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = '0;

    typedef struct packed {
        logic             valid;
        logic             regwr;
        logic             memrd;
        logic [SB_AW-1:0] rd;
        logic [SB_AW-1:0] rs;
        logic [SB_AW-1:0] rt;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_unit_scoreboard.sv
// In-flight destination tracker: entry 0 is EX, higher indices are older stages.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  bubble,
    input  sb_entry_t             id_entry,
    output sb_entry_t [DEPTH-1:0] entries
);

    sb_entry_t [DEPTH-1:0] sb_q;
    sb_entry_t [DEPTH-1:0] sb_d;

    always_comb begin
        sb_d = sb_q;
        if (!hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0] = bubble ? '0 : id_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign entries = sb_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: load-use stalls, redirect flushes, memory freeze and EX operand forwarding.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              id_valid,
    input  logic [REG_AW-1:0]                 id_rs,
    input  logic [REG_AW-1:0]                 id_rt,
    input  logic                              id_use_rs,
    input  logic                              id_use_rt,
    input  logic                              id_regwr,
    input  logic                              id_memrd,
    input  logic [REG_AW-1:0]                 id_rd,
    input  logic                              ex_redirect,
    input  logic                              mem_stall,
    output logic                              pc_wr,
    output logic                              ifid_wr,
    output logic                              ifid_flush,
    output logic                              idex_bubble,
    output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_a_sel,
    output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_b_sel,
    output logic [CNT_W-1:0]                  stall_cnt,
    output logic [CNT_W-1:0]                  flush_cnt
);

    localparam int DEPTH = FWD_STAGES + 1;
    localparam int SW    = $clog2(DEPTH);

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             id_entry;
    logic                  load_use;
    logic                  stall_inc;
    logic                  flush_inc;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic                  sb_unused;

    always_comb begin
        id_entry       = '0;
        id_entry.valid = id_valid;
        id_entry.regwr = id_regwr;
        id_entry.memrd = id_memrd;
        id_entry.rd    = SB_AW'(id_rd);
        id_entry.rs    = SB_AW'(id_rs);
        id_entry.rt    = SB_AW'(id_rt);
    end

    hazard_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .hold     (mem_stall),
        .bubble   (idex_bubble),
        .id_entry (id_entry),
        .entries  (entries)
    );

    // Only loads too young to forward (index < LOAD_LAT) force a stall.
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (entries[k].valid && entries[k].regwr && entries[k].memrd && entries[k].rd != '0) begin
                if (id_use_rs && entries[k].rd == id_entry.rs) load_use = 1'b1;
                if (id_use_rt && entries[k].rd == id_entry.rt) load_use = 1'b1;
            end
        end
        load_use = load_use & id_valid;
    end

    always_comb begin
        pc_wr       = 1'b1;
        ifid_wr     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (mem_stall) begin
            pc_wr     = 1'b0;
            ifid_wr   = 1'b0;
            stall_inc = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
        end else if (load_use) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    // Walk oldest to youngest so the youngest matching producer wins.
    function automatic logic [SW-1:0] fwd_pick(input sb_entry_t [DEPTH-1:0] sb,
                                               input logic [SB_AW-1:0] src);
        logic [SW-1:0] sel;
        sel = SW'(FWD_RF);
        if (sb[0].valid && src != '0) begin
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (sb[k].valid && sb[k].regwr && sb[k].rd == src &&
                    !(sb[k].memrd && k < LOAD_LAT + 1)) begin
                    sel = SW'(k);
                end
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel = fwd_pick(entries, entries[0].rs);
        fwd_b_sel = fwd_pick(entries, entries[0].rt);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_inc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Older entries' source fields are carried along but never compared.
    assign sb_unused = ^entries;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed hazard scenarios plus random traffic against a pipeline model.
module tb_pipe_hazard_unit;

    localparam int F  = 2;
    localparam int LL = 1;
    localparam int D  = F + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_regwr = 1'b0, id_memrd = 1'b0;
    logic       ex_redirect = 1'b0, mem_stall = 1'b0;
    logic       pc_wr, ifid_wr, ifid_flush, idex_bubble;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    // Model: one record per in-flight instruction, index 0 = EX.
    int m_v[D], m_wr[D], m_ld[D], m_rd[D], m_rs[D], m_rt[D];
    int m_stall, m_flush;
    int e_lu;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.REG_AW(5), .FWD_STAGES(F), .LOAD_LAT(LL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwr(id_regwr), .id_memrd(id_memrd),
        .id_rd(id_rd), .ex_redirect(ex_redirect), .mem_stall(mem_stall), .pc_wr(pc_wr),
        .ifid_wr(ifid_wr), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_fwd(input int src);
        if (m_v[0] == 0 || src == 0) return 0;
        for (int k = 1; k <= F; k++)
            if (m_v[k] != 0 && m_wr[k] != 0 && m_rd[k] == src && !(m_ld[k] != 0 && k <= LL))
                return k;
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < D; k++) begin
            m_v[k] = 0; m_wr[k] = 0; m_ld[k] = 0; m_rd[k] = 0; m_rs[k] = 0; m_rt[k] = 0;
        end
        m_stall = 0;
        m_flush = 0;
    endtask

    // Apply one cycle of ID/control inputs and compare every output against the model.
    task automatic drive(input string tag, input bit v, input int rs, input int rt, input bit urs,
                         input bit urt, input bit wr, input bit ld, input int rd,
                         input bit redir, input bit ms);
        int e_pc, e_flush, e_bub;
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
        id_regwr = wr; id_memrd = ld; id_rd = 5'(rd); ex_redirect = redir; mem_stall = ms;
        #2;
        e_lu = 0;
        for (int k = 0; k < LL; k++)
            if (m_v[k] != 0 && m_wr[k] != 0 && m_ld[k] != 0 && m_rd[k] != 0 &&
                ((urs && rs == m_rd[k]) || (urt && rt == m_rd[k])))
                e_lu = v;
        if (ms) begin
            e_pc = 0; e_flush = 0; e_bub = 0;
        end else if (redir) begin
            e_pc = 1; e_flush = 1; e_bub = 1;
        end else if (e_lu != 0) begin
            e_pc = 0; e_flush = 0; e_bub = 1;
        end else begin
            e_pc = 1; e_flush = 0; e_bub = 0;
        end
        chk({tag, ".pc_wr"}, int'(pc_wr), e_pc);
        chk({tag, ".ifid_wr"}, int'(ifid_wr), e_pc);
        chk({tag, ".ifid_flush"}, int'(ifid_flush), e_flush);
        chk({tag, ".idex_bubble"}, int'(idex_bubble), e_bub);
        chk({tag, ".fwd_a"}, int'(fwd_a_sel), model_fwd(m_rs[0]));
        chk({tag, ".fwd_b"}, int'(fwd_b_sel), model_fwd(m_rt[0]));
        chk({tag, ".stall_cnt"}, int'(stall_cnt), m_stall);
        chk({tag, ".flush_cnt"}, int'(flush_cnt), m_flush);
    endtask

    // Clock edge: advance the model using the inputs currently applied.
    task automatic tick();
        @(posedge clk);
        if (mem_stall) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            if (ex_redirect) begin
                if (m_flush < 65535) m_flush++;
            end else if (e_lu != 0) begin
                if (m_stall < 65535) m_stall++;
            end
            for (int k = D - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1];
                m_rd[k] = m_rd[k-1]; m_rs[k] = m_rs[k-1]; m_rt[k] = m_rt[k-1];
            end
            if (id_valid && !ex_redirect && e_lu == 0) begin
                m_v[0] = 1; m_wr[0] = int'(id_regwr); m_ld[0] = int'(id_memrd);
                m_rd[0] = int'(id_rd); m_rs[0] = int'(id_rs); m_rt[0] = int'(id_rt);
            end else begin
                m_v[0] = 0; m_wr[0] = 0; m_ld[0] = 0; m_rd[0] = 0; m_rs[0] = 0; m_rt[0] = 0;
            end
        end
        #1;
    endtask

    task automatic step(input string tag, input bit v, input int rs, input int rt, input bit urs,
                        input bit urt, input bit wr, input bit ld, input int rd,
                        input bit redir, input bit ms);
        drive(tag, v, rs, rt, urs, urt, wr, ld, rd, redir, ms);
        tick();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int s0, f0;
        model_clear();
        e_lu = 0;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.pc_wr_const", int'(pc_wr), 1);
        chk("reset.fwd_a_const", int'(fwd_a_sel), 0);
        chk("reset.stall_const", int'(stall_cnt), 0);
        tick();

        // add r3; add r4,r3,r3
        step("add_r3", 1, 1, 2, 1, 1, 1, 0, 3, 0, 0);
        step("add_r4", 1, 3, 3, 1, 1, 1, 0, 4, 0, 0);
        drive("back2back", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("back2back.a_const", int'(fwd_a_sel), 1);
        chk("back2back.b_const", int'(fwd_b_sel), 1);
        tick();
        nops(3);

        // add r3; nop; sub r5,r3,r1
        step("add_r3b", 1, 1, 2, 1, 1, 1, 0, 3, 0, 0);
        nops(1);
        step("sub_r5", 1, 3, 1, 1, 1, 1, 0, 5, 0, 0);
        drive("gap1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("gap1.a_const", int'(fwd_a_sel), 2);
        chk("gap1.b_const", int'(fwd_b_sel), 0);
        tick();
        nops(3);

        // add r0, then read r0
        step("add_r0", 1, 1, 2, 1, 1, 1, 0, 0, 0, 0);
        step("use_r0", 1, 0, 0, 1, 1, 1, 0, 6, 0, 0);
        drive("r0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0.a_const", int'(fwd_a_sel), 0);
        chk("r0.b_const", int'(fwd_b_sel), 0);
        tick();
        nops(3);

        // lw r5; add r6,r5,r2
        s0 = m_stall;
        step("lw_r5", 1, 1, 0, 1, 0, 1, 1, 5, 0, 0);
        drive("lu", 1, 5, 2, 1, 1, 1, 0, 6, 0, 0);
        chk("lu.pc_wr_const", int'(pc_wr), 0);
        chk("lu.bubble_const", int'(idex_bubble), 1);
        tick();
        step("lu_retry", 1, 5, 2, 1, 1, 1, 0, 6, 0, 0);
        chk("lu.stall_cnt_const", int'(stall_cnt), s0 + 1);
        drive("lu_ex", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_ex.a_const", int'(fwd_a_sel), 2);
        tick();
        nops(3);

        // load-use and redirect together: redirect wins
        s0 = m_stall;
        f0 = m_flush;
        step("lw_r5b", 1, 1, 0, 1, 0, 1, 1, 5, 0, 0);
        drive("lu_redir", 1, 5, 2, 1, 1, 1, 0, 6, 1, 0);
        chk("lu_redir.flush_const", int'(ifid_flush), 1);
        chk("lu_redir.pc_wr_const", int'(pc_wr), 1);
        tick();
        drive("after_redir", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("after_redir.stall_const", int'(stall_cnt), s0);
        chk("after_redir.flush_const", int'(flush_cnt), f0 + 1);
        tick();
        nops(3);

        // mem_stall freeze for 3 cycles
        step("add_r3c", 1, 1, 2, 1, 1, 1, 0, 3, 0, 0);
        step("add_r4c", 1, 3, 3, 1, 1, 1, 0, 4, 0, 0);
        s0 = m_stall;
        for (int i = 0; i < 3; i++) begin
            drive("mstall", 1, 4, 4, 1, 1, 1, 0, 7, 1, 1);
            chk("mstall.a_const", int'(fwd_a_sel), 1);
            chk("mstall.pc_wr_const", int'(pc_wr), 0);
            tick();
        end
        drive("mresume", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mresume.a_const", int'(fwd_a_sel), 1);
        chk("mresume.stall_const", int'(stall_cnt), s0 + 3);
        tick();

        // Random traffic on a small register set to provoke frequent hazards
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
        end

        // Reset mid-stream discards everything
        step("pre_rst", 1, 1, 2, 1, 1, 1, 1, 3, 0, 0);
        rst = 1'b1;
        id_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        e_lu = 0;
        drive("mid_rst", 1, 3, 3, 1, 1, 1, 0, 4, 0, 0);
        chk("mid_rst.stall_const", int'(stall_cnt), 0);
        chk("mid_rst.pc_wr_const", int'(pc_wr), 1);
        tick();

        // Saturate stall_cnt with a long memory freeze
        drive("sat_start", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (65540) @(posedge clk);
        m_stall = 65535;
        #1;
        drive("sat", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("sat.stall_const", int'(stall_cnt), 65535);
        tick();
        drive("sat_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_hold.stall_const", int'(stall_cnt), 65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
